hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32I core. Keeps its own shadow copy of
//  rs/rd/RegWrite/ResultSrc through the E, M and W stages. From these it drives forwarding
//  selects for the Execute ALU operands, load-use stalls for Fetch and Decode, and flushes
//  for taken branches and jumps. It sits beside the datapath and takes decoded fields from
//  Decode. It also keeps saturating stall and flush counters for performance debug.
// PARAMETERS
//  REG_AW   5   register address width (x0..x31)
//  CNT_W    32  width of each performance counter
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high; clears all state
//  Rs1D         in   REG_AW  rs1 field of InstrD[19:15]
//  Rs2D         in   REG_AW  rs2 field of InstrD[24:20]
//  RdD          in   REG_AW  rd field of InstrD[11:7]
//  RegWriteD    in   1       Decode-stage register write enable
//  ResultSrcD   in   2       Decode-stage result select; 2'b01 = load
//  PCSrcE       in   1       branch taken or jump in Execute
//  StallF       out  1       hold the PC register
//  StallD       out  1       hold the F/D pipeline register
//  FlushD       out  1       clear the F/D pipeline register
//  FlushE       out  1       clear the D/E pipeline register (drives Decode FlushE)
//  ForwardAE    out  2       SrcA select: 00 RD1_E, 10 ALUResultM, 01 ResultW
//  ForwardBE    out  2       SrcB select, same encoding as ForwardAE
//  stall_cnt    out  CNT_W   number of load-use stall cycles
//  flush_cnt    out  CNT_W   number of control-flush events (cycles with PCSrcE=1)
// BEHAVIOUR
//  - Reset: all shadow registers and counters go to 0, so RegWrite=0 in every stage.
//    With quiet inputs every output is 0. Reset asserted mid-operation clears state
//    at once, regardless of clk.
//  - Shadow pipe advances on every clk edge (the pipeline never stalls E, M or W):
//    - E <= D fields (Rs1, Rs2, Rd, RegWrite, ResultSrc). When FlushE=1, E instead
//      gets a bubble: all fields 0.
//    - M <= E (Rd, RegWrite).
//    - W <= M (Rd, RegWrite).
//  - Forwarding is combinational from shadow state. Rule for A (B is identical with Rs2E):
//    - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
//    - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
//    - else 00.
//    - M takes priority over W when both match. x0 is never forwarded.
//  - lwStall, combinational:
//    ResultSrcE==01 && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//    Rs fields are compared even for formats that do not use them (U/J); the resulting
//    spurious stall is accepted.
//  - Stall and flush outputs:
//    - StallF = StallD = lwStall & ~PCSrcE
//    - FlushD = PCSrcE
//    - FlushE = lwStall | PCSrcE
//  - PCSrcE and lwStall cannot both be valid, since only one instruction is in E.
//    If both are asserted anyway, PCSrcE wins: stalls are suppressed and both flushes fire.
//  - A load-use stall lasts exactly 1 cycle. The bubble in E clears the condition on the
//    next cycle.
//  - Counters:
//    - stall_cnt += 1 on each cycle with StallD=1.
//    - flush_cnt += 1 on each cycle with PCSrcE=1.
//    - Both saturate at 2^CNT_W-1 and never wrap.
//    - Counter outputs are registered (1-cycle latency). All other outputs are
//      combinational (0 latency).
// STRUCTURE
//  - Shared package riscv_pkg:
//    - RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10
//    - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
//    - REG_X0=5'd0
//  - Sub-module hazard_stage_tracker: the E/M/W shadow registers with bubble insert on
//    FlushE. It outputs Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, RdM, RegWriteM, RdW,
//    RegWriteW.
//  - The top level holds the forwarding, stall and flush logic and the counters.
// TESTING
//  1 Reset: assert reset mid-run -> all outputs 0 immediately; counters 0.
//  2 EX forward: add x5,x1,x2 then sub x6,x5,x3 -> in the cycle sub is in E,
//    ForwardAE=10, ForwardBE=00.
//  3 WB forward and priority: x5 written, then 1 unrelated instr, then use x5
//    -> ForwardAE=01. With x5 written in both M and W, the use gets ForwardAE=10.
//  4 x0 guard: addi x0,x0,1 then add x7,x0,x0 -> ForwardAE=ForwardBE=00.
//  5 Load-use: lw x4,0(x1) then add x8,x4,x2:
//    - cycle 1: StallF=StallD=FlushE=1.
//    - next cycle: no stall, and ForwardAE=01 once the add reaches E.
//    - stall_cnt=1.
//  6 Taken branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, StallF=0, flush_cnt=1.
//    Forcing lwStall and PCSrcE together gives StallF=0 with both flushes at 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I core: result-source selects, forwarding selects
// and the hard-wired zero register index.
package riscv_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage : riscv_pkg

// File: rtl/hazard_stage_tracker.sv
// Shadow copy of the register-address and write-control fields as they move
// through Execute, Memory and Writeback; FlushE turns the Execute entry into a bubble.
module hazard_stage_tracker #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              FlushE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic [REG_AW-1:0] RdM,
  output logic              RegWriteM,
  output logic [REG_AW-1:0] RdW,
  output logic              RegWriteW
);

  logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
  logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
  logic [REG_AW-1:0] rd_e_q,  rd_e_d;
  logic              rw_e_q,  rw_e_d;
  logic [1:0]        rsrc_e_q, rsrc_e_d;
  logic [REG_AW-1:0] rd_m_q;
  logic              rw_m_q;
  logic [REG_AW-1:0] rd_w_q;
  logic              rw_w_q;

  // A bubble is an all-zero entry: RegWrite=0 keeps it from forwarding or stalling.
  always_comb begin
    rs1_e_d  = Rs1D;
    rs2_e_d  = Rs2D;
    rd_e_d   = RdD;
    rw_e_d   = RegWriteD;
    rsrc_e_d = ResultSrcD;
    if (FlushE) begin
      rs1_e_d  = '0;
      rs2_e_d  = '0;
      rd_e_d   = '0;
      rw_e_d   = 1'b0;
      rsrc_e_d = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples the value of
  // the stage before it from the same clock edge; blocking would collapse the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e_q  <= '0;
      rs2_e_q  <= '0;
      rd_e_q   <= '0;
      rw_e_q   <= 1'b0;
      rsrc_e_q <= '0;
      rd_m_q   <= '0;
      rw_m_q   <= 1'b0;
      rd_w_q   <= '0;
      rw_w_q   <= 1'b0;
    end else begin
      rs1_e_q  <= rs1_e_d;
      rs2_e_q  <= rs2_e_d;
      rd_e_q   <= rd_e_d;
      rw_e_q   <= rw_e_d;
      rsrc_e_q <= rsrc_e_d;
      rd_m_q   <= rd_e_q;
      rw_m_q   <= rw_e_q;
      rd_w_q   <= rd_m_q;
      rw_w_q   <= rw_m_q;
    end
  end

  assign Rs1E       = rs1_e_q;
  assign Rs2E       = rs2_e_q;
  assign RdE        = rd_e_q;
  assign RegWriteE  = rw_e_q;
  assign ResultSrcE = rsrc_e_q;
  assign RdM        = rd_m_q;
  assign RegWriteM  = rw_m_q;
  assign RdW        = rd_w_q;
  assign RegWriteW  = rw_w_q;

endmodule : hazard_stage_tracker

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: ALU operand forwarding,
// load-use stalls, control flushes and saturating stall/flush event counters.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [REG_AW-1:0] X0      = REG_AW'(REG_X0);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              rw_e, rw_m, rw_w;
  logic [1:0]        rsrc_e;
  logic              lw_stall;

  hazard_stage_tracker #(
    .REG_AW(REG_AW)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .FlushE     (FlushE),
    .Rs1E       (rs1_e),
    .Rs2E       (rs2_e),
    .RdE        (rd_e),
    .RegWriteE  (rw_e),
    .ResultSrcE (rsrc_e),
    .RdM        (rd_m),
    .RegWriteM  (rw_m),
    .RdW        (rd_w),
    .RegWriteW  (rw_w)
  );

  // The younger producer (Memory) holds the newer value, so it wins over Writeback.
  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (rw_m && (rd_m != X0) && (rd_m == rs))
      sel = FWD_M;
    else if (rw_w && (rd_w != X0) && (rd_w == rs))
      sel = FWD_W;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(rs1_e);
  assign ForwardBE = fwd_sel(rs2_e);

  // rs fields are compared even for U/J formats; the occasional spurious stall is harmless.
  assign lw_stall = (rsrc_e == RESULT_MEM) && rw_e && (rd_e != X0) &&
                    ((rd_e == Rs1D) || (rd_e == Rs2D));

  // A taken branch discards the stalled instruction anyway, so it overrides the stall.
  assign StallF = lw_stall & ~PCSrcE;
  assign StallD = lw_stall & ~PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = lw_stall | PCSrcE;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // NOTE: every next-state value gets a default first so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (PCSrcE && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Directed pipeline scenarios followed by random decode traffic, all compared against
// an in-flight instruction history model; a 3-bit-counter copy exercises saturation.
module tb_hazard_unit;
  import riscv_pkg::*;

  localparam int SMALL_W = 3;
  localparam int SMALL_MAX = (1 << SMALL_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE;

  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, flush_cnt;

  logic              s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [1:0]        s_ForwardAE, s_ForwardBE;
  logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

  hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.REG_AW(5), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] rsrc;
  } instr_t;

  // In-flight history: [0] is in Execute, [1] one instruction older, [2] two older.
  instr_t      hist[$];
  int unsigned n_stall;
  int unsigned n_flush;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
    n_stall = 0;
    n_flush = 0;
  endtask

  // Search older in-flight writers, youngest first; x0 never supplies a value.
  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    for (int age = 1; age <= 2; age++) begin
      if (hist[age].rw && hist[age].rd != 5'd0 && hist[age].rd == src)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic exp_load_use();
    instr_t e;
    e = hist[0];
    return (e.rsrc == 2'b01) && e.rw && (e.rd != 5'd0) && (e.rd == Rs1D || e.rd == Rs2D);
  endfunction

  function automatic int unsigned sat_small(input int unsigned n);
    return (n > SMALL_MAX) ? SMALL_MAX : n;
  endfunction

  task automatic set_d(input int rs1, input int rs2, input int rd, input bit rw,
                       input logic [1:0] rsrc, input bit pc);
    Rs1D       = 5'(rs1);
    Rs2D       = 5'(rs2);
    RdD        = 5'(rd);
    RegWriteD  = rw;
    ResultSrcD = rsrc;
    PCSrcE     = pc;
    #1;
  endtask

  task automatic quiet();
    set_d(0, 0, 0, 1'b0, RESULT_ALU, 1'b0);
  endtask

  // Compare every output with the model, then clock once and advance the model.
  task automatic cycle();
    logic   lw, st, fe;
    instr_t nxt;
    #2;
    lw = exp_load_use();
    st = lw && !PCSrcE;
    fe = lw || PCSrcE;
    check("StallF",    32'(StallF),    32'(st));
    check("StallD",    32'(StallD),    32'(st));
    check("FlushD",    32'(FlushD),    32'(PCSrcE));
    check("FlushE",    32'(FlushE),    32'(fe));
    check("ForwardAE", 32'(ForwardAE), 32'(exp_fwd(hist[0].rs1)));
    check("ForwardBE", 32'(ForwardBE), 32'(exp_fwd(hist[0].rs2)));
    check("stall_cnt", stall_cnt,      n_stall);
    check("flush_cnt", flush_cnt,      n_flush);
    check("stall_cnt_sat", 32'(s_stall_cnt), sat_small(n_stall));
    check("flush_cnt_sat", 32'(s_flush_cnt), sat_small(n_flush));
    nxt = fe ? instr_t'('0) : instr_t'{Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD};
    @(posedge clk);
    #1;
    if (st) n_stall++;
    if (PCSrcE) n_flush++;
    hist.push_front(nxt);
    void'(hist.pop_back());
  endtask

  initial begin
    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; ResultSrcD = '0; PCSrcE = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state with quiet inputs
    quiet();
    check("rst_StallF", 32'(StallF), 0);
    check("rst_FlushE", 32'(FlushE), 0);
    check("rst_FwdA",   32'(ForwardAE), 0);
    check("rst_stall_cnt", stall_cnt, 0);
    cycle();

    // Execute-stage forward: add x5,x1,x2 ; sub x6,x5,x3
    set_d(1, 2, 5, 1'b1, RESULT_ALU, 1'b0); cycle();
    set_d(5, 3, 6, 1'b1, RESULT_ALU, 1'b0); cycle();
    quiet();
    check("ex_fwd_A", 32'(ForwardAE), 32'(2'b10));
    check("ex_fwd_B", 32'(ForwardBE), 32'(2'b00));
    cycle();

    // Writeback forward across one unrelated instruction
    set_d(1, 2, 5, 1'b1, RESULT_ALU, 1'b0); cycle();
    set_d(1, 2, 9, 1'b1, RESULT_ALU, 1'b0); cycle();
    set_d(5, 0, 10, 1'b1, RESULT_ALU, 1'b0); cycle();
    quiet();
    check("wb_fwd_A", 32'(ForwardAE), 32'(2'b01));
    cycle();

    // x5 in both Memory and Writeback: the younger writer wins
    set_d(1, 2, 5, 1'b1, RESULT_ALU, 1'b0); cycle();
    set_d(3, 4, 5, 1'b1, RESULT_ALU, 1'b0); cycle();
    set_d(5, 5, 11, 1'b1, RESULT_ALU, 1'b0); cycle();
    quiet();
    check("prio_fwd_A", 32'(ForwardAE), 32'(2'b10));
    check("prio_fwd_B", 32'(ForwardBE), 32'(2'b10));
    cycle();

    // x0 guard: addi x0,x0,1 ; add x7,x0,x0
    set_d(0, 0, 0, 1'b1, RESULT_ALU, 1'b0); cycle();
    set_d(0, 0, 7, 1'b1, RESULT_ALU, 1'b0); cycle();
    quiet();
    check("x0_fwd_A", 32'(ForwardAE), 32'(2'b00));
    check("x0_fwd_B", 32'(ForwardBE), 32'(2'b00));
    cycle();

    // Reset asserted mid-cycle acts without a clock edge
    set_d(1, 0, 4, 1'b1, RESULT_MEM, 1'b0); cycle();
    set_d(4, 5, 12, 1'b1, RESULT_ALU, 1'b0);
    check("pre_rst_stall", 32'(StallD), 1);
    quiet();
    reset = 1'b1;
    #1;
    check("async_rst_StallF", 32'(StallF), 0);
    check("async_rst_StallD", 32'(StallD), 0);
    check("async_rst_FlushE", 32'(FlushE), 0);
    check("async_rst_FlushD", 32'(FlushD), 0);
    check("async_rst_FwdA",   32'(ForwardAE), 0);
    check("async_rst_FwdB",   32'(ForwardBE), 0);
    check("async_rst_scnt",   stall_cnt, 0);
    check("async_rst_fcnt",   flush_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Load-use: lw x4,0(x1) ; add x8,x4,x2
    set_d(1, 0, 4, 1'b1, RESULT_MEM, 1'b0); cycle();
    set_d(4, 2, 8, 1'b1, RESULT_ALU, 1'b0);
    check("lu_StallF", 32'(StallF), 1);
    check("lu_StallD", 32'(StallD), 1);
    check("lu_FlushE", 32'(FlushE), 1);
    cycle();
    check("lu_release", 32'(StallF), 0);
    cycle();
    quiet();
    check("lu_fwd_A", 32'(ForwardAE), 32'(2'b01));
    check("lu_stall_cnt", stall_cnt, 1);
    cycle();

    // Taken branch
    set_d(0, 0, 0, 1'b0, RESULT_ALU, 1'b1);
    check("br_FlushD", 32'(FlushD), 1);
    check("br_FlushE", 32'(FlushE), 1);
    check("br_StallF", 32'(StallF), 0);
    cycle();
    quiet();
    check("br_flush_cnt", flush_cnt, 1);
    cycle();

    // Load-use and branch together: branch wins
    set_d(1, 0, 4, 1'b1, RESULT_MEM, 1'b0); cycle();
    set_d(4, 0, 8, 1'b1, RESULT_ALU, 1'b1);
    check("both_StallF", 32'(StallF), 0);
    check("both_StallD", 32'(StallD), 0);
    check("both_FlushD", 32'(FlushD), 1);
    check("both_FlushE", 32'(FlushE), 1);
    cycle();
    quiet(); cycle();

    // Random decode traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      cycle();
    end
    quiet(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_unit
